// File: rtl/rsr_shift_sequencer_if.sv
// Issue/writeback bundle between the ALU issue logic and rsr_shift_sequencer.
// The master drives requests and the slave (the sequencer) returns status, result and flags.
interface rsr_shift_sequencer_if #(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 5
);

  logic               start;
  logic [DATA_W-1:0]  op_a;
  logic [SHAMT_W-1:0] shamt;
  logic [1:0]         mode;
  logic               s_in;
  logic               ready;
  logic               busy;
  logic               done;
  logic [DATA_W-1:0]  result;
  logic [3:0]         flags;

  modport master (
    output start, op_a, shamt, mode, s_in,
    input  ready, busy, done, result, flags
  );

  modport slave (
    input  start, op_a, shamt, mode, s_in,
    output ready, busy, done, result, flags
  );

endinterface

// File: rtl/rsr_shift_sequencer.sv
// Multi-cycle right shift/rotate sequencer: splits a 0-31 bit amount into steps of at most
// STEP_MAX bits and owns the NZCV flags. Optional arithmetic shift is enabled by RSR_ARITH_EN.
module rsr_shift_sequencer #(
  parameter int DATA_W  = 32,
  parameter int STEP_W  = 4,
  parameter int SHAMT_W = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  rsr_shift_sequencer_if.slave ctrl_io
);

  localparam int                 STEP_MAX     = 2 ** (STEP_W - 1) - 1;
  localparam logic [SHAMT_W-1:0] STEP_MAX_AMT = SHAMT_W'(STEP_MAX);

  typedef enum logic [1:0] {
    IDLE,
    STEP,
    DONE
  } state_e;

  state_e             state_q, state_d;
  logic [DATA_W-1:0]  work_q, work_d;
  logic [SHAMT_W-1:0] remaining_q, remaining_d;
  logic [1:0]         mode_q, mode_d;
  logic               sIn_q, sIn_d;
  logic               carry_q, carry_d;
  logic [DATA_W-1:0]  result_q, result_d;
  logic [3:0]         flags_q, flags_d;

  logic [SHAMT_W-1:0] stepAmt;
  logic [DATA_W-1:0]  lsrVal;
  logic [DATA_W-1:0]  rorVal;
  logic [DATA_W-1:0]  stepVal;
  logic               shiftCarry;
  logic               stepCarry;
  logic               isRor;
  logic               isAsr;
  logic               doneEntry;

`ifdef RSR_ARITH_EN
  logic sign_q, sign_d;
  assign isAsr = (mode_q == 2'b10);
`else
  logic unusedModeHi;
  assign unusedModeHi = mode_q[1];
  assign isAsr        = 1'b0;
`endif

  assign isRor = mode_q[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (ctrl_io.start) begin
          state_d = (ctrl_io.shamt != '0) ? STEP : DONE;
        end
      end
      STEP: begin
        state_d = (remaining_d != '0) ? STEP : DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    ctrl_io.ready  = (state_q == IDLE);
    ctrl_io.busy   = (state_q == STEP) || (state_q == DONE);
    ctrl_io.done   = (state_q == DONE);
    ctrl_io.result = result_q;
    ctrl_io.flags  = flags_q;
  end

  // One step of the datapath; stepAmt is never zero while in STEP.
  always_comb begin
    stepAmt    = (remaining_q > STEP_MAX_AMT) ? STEP_MAX_AMT : remaining_q;
    lsrVal     = work_q >> stepAmt;
    rorVal     = lsrVal | (work_q << (DATA_W - int'(stepAmt)));
    shiftCarry = work_q[stepAmt - SHAMT_W'(1)];
    stepVal    = lsrVal;
    stepCarry  = shiftCarry;
    if (isRor) begin
      stepVal   = rorVal;
      stepCarry = rorVal[DATA_W-1];
    end else if (isAsr) begin
`ifdef RSR_ARITH_EN
      stepVal = lsrVal | (~({DATA_W{1'b1}} >> stepAmt) & {DATA_W{sign_q}});
`endif
    end
  end

  always_comb begin
    work_d      = work_q;
    remaining_d = remaining_q;
    mode_d      = mode_q;
    sIn_d       = sIn_q;
    carry_d     = carry_q;
`ifdef RSR_ARITH_EN
    sign_d      = sign_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (ctrl_io.start) begin
          work_d      = ctrl_io.op_a;
          remaining_d = ctrl_io.shamt;
          mode_d      = ctrl_io.mode;
          sIn_d       = ctrl_io.s_in;
          // A zero-length operation must leave C untouched, so seed it with the current flag.
          carry_d     = flags_q[1];
`ifdef RSR_ARITH_EN
          sign_d      = ctrl_io.op_a[DATA_W-1];
`endif
        end
      end
      STEP: begin
        work_d      = stepVal;
        remaining_d = remaining_q - stepAmt;
        carry_d     = stepCarry;
      end
      default: begin
      end
    endcase
  end

  // Result and flags load on the edge into DONE so both are valid during the done pulse.
  always_comb begin
    doneEntry = (state_d == DONE) && (state_q != DONE);
    result_d  = result_q;
    flags_d   = flags_q;
    if (doneEntry) begin
      result_d = work_d;
      if (sIn_d) begin
        flags_d = {work_d[DATA_W-1], (work_d == '0), carry_d, flags_q[0]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      work_q      <= '0;
      remaining_q <= '0;
      mode_q      <= '0;
      sIn_q       <= 1'b0;
      carry_q     <= 1'b0;
      result_q    <= '0;
      flags_q     <= 4'b0000;
`ifdef RSR_ARITH_EN
      sign_q      <= 1'b0;
`endif
    end else begin
      work_q      <= work_d;
      remaining_q <= remaining_d;
      mode_q      <= mode_d;
      sIn_q       <= sIn_d;
      carry_q     <= carry_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
`ifdef RSR_ARITH_EN
      sign_q      <= sign_d;
`endif
    end
  end

endmodule

// File: tb/tb_rsr_shift_sequencer.sv
// Directed plus randomized bench for rsr_shift_sequencer using a bit-serial reference model
// and an in-order scoreboard of expected result, flags and latency.
module tb_rsr_shift_sequencer;

  logic clk;
  logic rst;
  int   cycleCnt;
  int   vectors;
  int   miscompares;

  rsr_shift_sequencer_if #(.DATA_W(32), .SHAMT_W(5)) bus ();

  rsr_shift_sequencer #(.DATA_W(32), .STEP_W(4), .SHAMT_W(5)) dut (
    .clk     (clk),
    .rst     (rst),
    .ctrl_io (bus)
  );

  typedef struct {
    logic [31:0] res;
    logic [3:0]  flg;
    int          lat;
    int          acceptCyc;
  } exp_t;

  exp_t       sbQ[$];
  logic [3:0] modelFlags;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cycleCnt = 0;
  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  // Bit-serial reference: one bit per iteration, carry is the bit leaving position 0.
  task automatic modelOp(input logic [31:0] a, input logic [4:0] sh, input logic [1:0] md,
                         input logic s, output logic [31:0] r);
    logic c;
    logic sign;
    c    = 1'b0;
    sign = a[31];
    r    = a;
    for (int i = 0; i < int'(sh); i++) begin
      c = r[0];
      if (md[0]) r = {r[0], r[31:1]};
`ifdef RSR_ARITH_EN
      else if (md == 2'b10) r = {sign, r[31:1]};
`endif
      else r = {1'b0, r[31:1]};
    end
    if (s) modelFlags = {r[31], (r == 32'h0), (sh == 5'd0) ? modelFlags[1] : c, modelFlags[0]};
  endtask

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] a, input logic [4:0] sh, input logic [1:0] md,
                               input logic s);
    int   n;
    exp_t e;
    logic [31:0] r;
    n = 0;
    @(negedge clk);
    while (!bus.ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.ready) checkValue("readyTimeout", 32'(bus.ready), 32'd1);
    bus.op_a  = a;
    bus.shamt = sh;
    bus.mode  = md;
    bus.s_in  = s;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    modelOp(a, sh, md, s, r);
    e.res       = r;
    e.flg       = modelFlags;
    e.lat       = (int'(sh) + 6) / 7 + 1;
    e.acceptCyc = cycleCnt;
    sbQ.push_back(e);
  endtask

  task automatic checkOutput(input string tag);
    int   n;
    exp_t e;
    n = 0;
    while (!bus.done && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!bus.done) begin
      checkValue({tag, "_doneTimeout"}, 32'(bus.done), 32'd1);
      if (sbQ.size() > 0) void'(sbQ.pop_front());
      return;
    end
    if (sbQ.size() == 0) begin
      checkValue({tag, "_sbEmpty"}, 32'd0, 32'd1);
      return;
    end
    e = sbQ.pop_front();
    checkValue({tag, "_result"}, bus.result, e.res);
    checkValue({tag, "_flags"}, 32'(bus.flags), 32'(e.flg));
    checkValue({tag, "_latency"}, 32'(cycleCnt - e.acceptCyc + 1), 32'(e.lat));
  endtask

  initial begin
    int extra;
    vectors     = 0;
    miscompares = 0;
    modelFlags  = 4'b0000;
    rst         = 1'b1;
    bus.start   = 1'b0;
    bus.op_a    = '0;
    bus.shamt   = '0;
    bus.mode    = '0;
    bus.s_in    = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkValue("rst_ready", 32'(bus.ready), 32'd1);
    checkValue("rst_busy", 32'(bus.busy), 32'd0);
    checkValue("rst_done", 32'(bus.done), 32'd0);
    checkValue("rst_result", bus.result, 32'd0);
    checkValue("rst_flags", 32'(bus.flags), 32'd0);

    applyStimulus(32'd3, 5'd1, 2'b00, 1'b1);
    checkOutput("lsr3by1");
    applyStimulus(32'hFFFF_FFFF, 5'd9, 2'b01, 1'b1);
    checkOutput("rorOnesBy9");
    applyStimulus(32'd16, 5'd10, 2'b00, 1'b1);
    checkOutput("lsr16by10");
    applyStimulus(32'd0, 5'd0, 2'b00, 1'b1);
    checkOutput("zeroShamt");

    applyStimulus(32'hFFFF_FFFF, 5'd9, 2'b01, 1'b1);
    checkOutput("preload");
    applyStimulus(32'hFFFF_FFFA, 5'd4, 2'b00, 1'b0);
    bus.op_a  = 32'h1234_5678;
    bus.shamt = 5'd0;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    checkOutput("noFlagUpdate");
    extra = 0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (bus.done) extra++;
    end
    checkValue("startIgnoredBusy", 32'(extra), 32'd0);

    applyStimulus(32'd1, 5'd31, 2'b01, 1'b1);
    checkOutput("ror1by31");

    applyStimulus(32'd1, 5'd31, 2'b01, 1'b1);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    modelFlags = 4'b0000;
    void'(sbQ.pop_front());
    checkValue("midRst_ready", 32'(bus.ready), 32'd1);
    checkValue("midRst_busy", 32'(bus.busy), 32'd0);
    checkValue("midRst_flags", 32'(bus.flags), 32'd0);
    checkValue("midRst_result", bus.result, 32'd0);
    extra = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (bus.done) extra++;
    end
    checkValue("midRst_noDone", 32'(extra), 32'd0);

    applyStimulus(32'h8000_0000, 5'd8, 2'b10, 1'b1);
    checkOutput("arith");

    for (int i = 0; i < 8; i++) begin
      applyStimulus($urandom, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)));
      checkOutput("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rsr_shift_sequencer.md
Name: rsr_shift_sequencer

Overview:
- Multi-cycle controller that drives the 4-bit-amount rotate/shift-right datapath to perform full 0–31 bit right shifts and rotates on 32-bit operands.
- Splits each shift amount into steps of at most STEP_MAX bits, runs one step per cycle and owns the architectural NZCV flag register.
- Sits between the ALU issue logic and the flag/result writeback.

Parameters:
DATA_W, 32, operand/result width.
STEP_W, 4, signed width of the per-step shift amount; STEP_MAX = 2^(STEP_W-1)-1 = 7.
SHAMT_W, 5, width of the requested total shift amount.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  request a new operation; accepted only when ready=1.
op_a  input  DATA_W  operand, captured on accept.
shamt  input  SHAMT_W  total shift amount, captured on accept.
mode  input  2  bit0: 0 = logical shift right, 1 = rotate right; bit1 = arithmetic (feature only).
s_in  input  1  flag-update enable, captured on accept.
ready  output  1  high in IDLE.
busy  output  1  high in STEP and DONE.
done  output  1  one-cycle pulse; result and flags are valid in that cycle.
result  output  DATA_W  final value, held until the next accept.
flags  output  4  registered {N,Z,C,V}.

Behaviour:
- Reset (sync, rst=1 at clk edge) forces the following, regardless of state, including mid-operation:
  - state=IDLE, ready=1, busy=0, done=0.
  - result=0, flags=4'b0000.
  - The in-flight operation is discarded with no done pulse.
- FSM states: IDLE, STEP, DONE.
- IDLE:
  - On start=1, capture op_a into the working register and shamt into remaining.
  - Also capture mode and s_in.
  - Go to STEP if shamt!=0, else go to DONE.
- STEP:
  - Compute step = min(remaining, STEP_MAX).
  - Shift or rotate the working register right by step.
  - remaining -= step.
  - Record the carry bit. For shifts, carry = the last bit shifted out (bit step-1 of the pre-step value). For rotates, carry = the new bit[DATA_W-1].
  - Stay in STEP while remaining != 0 after the update, else go to DONE.
- DONE:
  - done=1 for exactly one cycle and result = working register.
  - If s_in=1: N = result[31], Z = (result==0).
    - C = last carry, or unchanged when shamt=0.
    - V is unchanged.
  - If s_in=0, flags are unchanged.
  - Next state is IDLE.
- Latency: an accept at edge k gives done high in cycle k+ceil(shamt/7)+1. shamt=0 gives done one cycle after accept. shamt=31 takes 5 steps (7,7,7,7,3).
- start while busy is ignored, not queued; input changes during busy have no effect.
- Back-to-back operation: start may be accepted in the cycle after done, because ready=1 again in IDLE.
- For mode=ROR, any shift amount is valid. For mode=LSR with shamt≥32 (unreachable with SHAMT_W=5), result=0.
- Vacated bits are zero-filled for LSR and wrap from bit0 for ROR.

Optional Feature:
- Macro: RSR_ARITH_EN.
- Defined: mode=2'b10 selects arithmetic shift right. Each step sign-fills from op_a[31], and carry follows the LSR rule.
- Not defined: mode[1] is ignored and mode=2'b10 behaves as LSR.
- Flags rules are identical in both builds.

Test Plan:
- op_a=3, shamt=1, LSR, s_in=1 -> 1 step; done 2 cycles after accept; result=1; flags=0010 (C=1).
- op_a=32'hFFFFFFFF, shamt=9, ROR, s_in=1 -> steps 7,2; done at accept+3; result=32'hFFFFFFFF; flags=1010.
- op_a=16, shamt=10, LSR, s_in=1 -> steps 7,3; result=0; flags=0100 (Z=1, C=0); then op_a=0, shamt=0, s_in=1 -> done at accept+1; Z=1, C held.
- Preload flags=1010, then op_a=-6, shamt=4, LSR, s_in=0 -> result=32'h0FFFFFFF; flags remain 1010; a start pulse in the STEP cycle is ignored (no second done).
- shamt=31, ROR, op_a=1 -> 5 steps; result=2; flags=0000. Assert rst on step 3 -> next cycle ready=1, done never pulses, flags=0000.
- RSR_ARITH_EN build: op_a=32'h80000000, shamt=8, mode=2'b10 -> result=32'hFF800000; N=1. Non-feature build with the same stimulus -> result=32'h00800000.
